// File: rtl/loadstore_unit.sv
// loadstore_unit: memory-access stage behind the execution unit. Runs one
// req/ack data-memory transaction per load/store and formats byte/half/word
// lanes. Loads return sign- or zero-extended data for register writeback.
// Optional build macro LSU_ALIGN_CHECK_EN:
//   defined   - misaligned half/word accesses skip the bus and pulse fault.
//   undefined - fault is tied low, and misaligned addresses are truncated
//               down to the access size.
module loadstore_unit #(
  parameter int REG_IDX_W = 6
) (
  input  logic                 wb_clk_i,
  input  logic                 rst,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 sign_extend,
  input  logic [1:0]           loadstore_size,
  input  logic [31:0]          loadstore_address,
  input  logic [31:0]          store_data,
  input  logic [REG_IDX_W-1:0] dest_idx,
  input  logic [1:0]           dest_mask,
  output logic                 busy,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_idx,
  output logic [1:0]           wb_mask,
  output logic [31:0]          wb_val,
  output logic                 fault,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_sel,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 req_c, misal_c;
  logic [31:0]          eff_addr_c;
  logic [3:0]           sel_c;
  logic [31:0]          wdata_c;
  logic [7:0]           byte_c;
  logic [15:0]          half_c;
  logic [31:0]          fmt_c;

  logic [31:0]          addr_q, wdata_q, wb_val_q;
  logic [3:0]           sel_q;
  logic [1:0]           size_q, lane_q, mask_q;
  logic                 sign_q, we_q, load_q, fault_q;
  logic [REG_IDX_W-1:0] idx_q;

  assign req_c = is_load | is_store;

  // Classify alignment and form the effective address used for lane select
  always_comb begin
    misal_c    = 1'b0;
    eff_addr_c = loadstore_address;
`ifdef LSU_ALIGN_CHECK_EN
    case (loadstore_size)
      2'd0:    misal_c = 1'b0;
      2'd1:    misal_c = loadstore_address[0];
      default: misal_c = |loadstore_address[1:0];
    endcase
`else
    case (loadstore_size)
      2'd0:    eff_addr_c = loadstore_address;
      2'd1:    eff_addr_c[0] = 1'b0;
      default: eff_addr_c[1:0] = 2'b00;
    endcase
`endif
  end

  // Byte-lane enables and replicated write data for the request
  always_comb begin
    case (loadstore_size)
      2'd0: begin
        sel_c   = 4'b0001 << eff_addr_c[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'd1: begin
        sel_c   = eff_addr_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Extract and extend the addressed lane of the returning read data
  always_comb begin
    byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
    half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    fmt_c = {{24{sign_q & byte_c[7]}}, byte_c};
      2'd1:    fmt_c = {{16{sign_q & half_c[15]}}, half_c};
      default: fmt_c = mem_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_c) state_d = misal_c ? S_DONE : S_BUS;
      S_BUS:   if (mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Latch the request on acceptance and the formatted load data on ack
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      size_q   <= '0;
      lane_q   <= '0;
      sign_q   <= 1'b0;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      fault_q  <= 1'b0;
      idx_q    <= '0;
      mask_q   <= '0;
      wb_val_q <= '0;
    end else begin
      if (state_q == S_IDLE && req_c) begin
        addr_q  <= {eff_addr_c[31:2], 2'b00};
        wdata_q <= wdata_c;
        sel_q   <= sel_c;
        size_q  <= loadstore_size;
        lane_q  <= eff_addr_c[1:0];
        sign_q  <= sign_extend;
        we_q    <= is_store;
        load_q  <= is_load & ~is_store;
        fault_q <= misal_c;
        idx_q   <= dest_idx;
        mask_q  <= dest_mask;
      end
      if (state_q == S_BUS && mem_ack) wb_val_q <= fmt_c;
    end
  end

  assign busy      = (req_c && state_q == S_IDLE) || state_q == S_BUS;
  assign mem_req   = (state_q == S_BUS);
  assign mem_we    = mem_req & we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = (state_q == S_DONE) && load_q && !fault_q;
  assign wb_idx    = idx_q;
  assign wb_mask   = mask_q;
  assign wb_val    = wb_val_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign fault     = (state_q == S_DONE) && fault_q;
`else
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_loadstore_unit.sv
// tb_loadstore_unit: scoreboard bench for loadstore_unit. A byte-addressed
// memory model serves the bus; expected bus ops and retirements are queued
// at issue time and checked by separate responder/monitor processes.
module tb_loadstore_unit;
  localparam int IW = 6;

  logic          wb_clk_i = 1'b0;
  logic          rst = 1'b1;
  logic          is_load = 1'b0, is_store = 1'b0, sign_extend = 1'b0;
  logic [1:0]    loadstore_size = '0;
  logic [31:0]   loadstore_address = '0, store_data = '0;
  logic [IW-1:0] dest_idx = '0;
  logic [1:0]    dest_mask = '0;
  logic          busy, wb_valid, fault, mem_req, mem_we;
  logic [IW-1:0] wb_idx;
  logic [1:0]    wb_mask;
  logic [31:0]   wb_val, mem_addr, mem_wdata;
  logic [3:0]    mem_sel;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;

  loadstore_unit #(.REG_IDX_W(IW)) dut (
    .wb_clk_i(wb_clk_i), .rst(rst), .is_load(is_load), .is_store(is_store),
    .sign_extend(sign_extend), .loadstore_size(loadstore_size),
    .loadstore_address(loadstore_address), .store_data(store_data),
    .dest_idx(dest_idx), .dest_mask(dest_mask), .busy(busy),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_mask(wb_mask), .wb_val(wb_val),
    .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned total = 0, bad = 0;

  typedef struct {
    bit            is_fault;
    logic [IW-1:0] idx;
    logic [1:0]    mask;
    logic [31:0]   val;
  } retire_t;
  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  retire_t     exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] mem [int unsigned];

  bit resp_en    = 1'b1;
  bit force_ack  = 1'b0;
  bit ack_always = 1'b0;
  int fixed_delay = -1;
  int unsigned last_delay = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void fail_event(string name, logic [31:0] got);
    total++;
    bad++;
    $display("FAIL %s: got %h expected none", name, got);
  endfunction

  function automatic logic [31:0] mem_word(int unsigned w);
    if (mem.exists(w)) return mem[w];
    return w * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // Memory responder: checks each new bus op, then acks after a delay
  initial begin
    bit          active = 1'b0;
    int unsigned cnt = 0;
    bus_t        b;
    forever begin
      @(negedge wb_clk_i);
      if (!resp_en) begin
        active    = 1'b0;
        mem_ack   = force_ack;
        mem_rdata = 32'h5555AAAA;
      end else begin
        mem_ack = ack_always;
        if (active && !mem_req) begin
          fail_event("req_dropped", {31'd0, mem_req});
          active = 1'b0;
        end
        if (mem_req && !active) begin
          active = 1'b1;
          cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
          last_delay = cnt;
          if (bus_q.size() == 0) fail_event("unexpected_bus", mem_addr);
          else begin
            b = bus_q.pop_front();
            check("bus_we", mem_we, b.we);
            check("bus_sel", mem_sel, b.sel);
            check("bus_addr", mem_addr, b.addr);
            if (b.we) check("bus_wdata", mem_wdata, b.wdata);
          end
        end
        if (active) begin
          if (cnt == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr >> 2);
            active    = 1'b0;
          end else begin
            cnt--;
          end
        end else if (!mem_req && !ack_always && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Retirement monitor
  initial begin
    retire_t e;
    forever begin
      @(negedge wb_clk_i);
      if (wb_valid || fault) begin
        check("retire_busy", busy, 0);
        if (exp_q.size() == 0) fail_event("unexpected_retire", wb_val);
        else begin
          e = exp_q.pop_front();
          check("retire_fault", fault, e.is_fault);
          check("retire_wb_valid", wb_valid, !e.is_fault);
          if (!e.is_fault) begin
            check("wb_idx", wb_idx, e.idx);
            check("wb_mask", wb_mask, e.mask);
            check("wb_val", wb_val, e.val);
          end
        end
      end
    end
  end

  task automatic issue(input bit ld, input bit sg, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [IW-1:0] idx, input logic [1:0] msk);
    int unsigned off, nbytes, cyc, exp_cyc, wi;
    bit          mis, done;
    logic [31:0] w, v, m;
    retire_t     r;
    bus_t        b;
    off    = a % 4;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = (off % nbytes) != 0;
`ifndef LSU_ALIGN_CHECK_EN
    if (mis) begin
      off = off - off % nbytes;
      mis = 1'b0;
    end
`endif
    wi = a / 4;
    w  = mem_word(wi);
    m  = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 1);
    if (!mis) begin
      b.we    = !ld;
      b.addr  = a - a % 4;
      b.sel   = 4'(((1 << nbytes) - 1) << off);
      b.wdata = (nbytes == 1) ? 32'(d[7:0]) * 32'h01010101 :
                (nbytes == 2) ? 32'(d[15:0]) * 32'h00010001 : d;
      bus_q.push_back(b);
      if (!ld) begin
        for (int unsigned i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
        mem[wi] = w;
      end else begin
        v = (w >> (8 * off)) & m;
        if (sg && nbytes < 4 && v[8*nbytes-1]) v = v | ~m;
        r.is_fault = 1'b0; r.idx = idx; r.mask = msk; r.val = v;
        exp_q.push_back(r);
      end
    end else begin
      r.is_fault = 1'b1; r.idx = idx; r.mask = msk; r.val = '0;
      exp_q.push_back(r);
    end
    @(posedge wb_clk_i) #1;
    is_load = ld; is_store = !ld; sign_extend = sg; loadstore_size = sz;
    loadstore_address = a; store_data = d; dest_idx = idx; dest_mask = msk;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge wb_clk_i);
      cyc++;
      if (!busy) done = 1'b1;
    end
    exp_cyc = mis ? 2 : last_delay + 3;
    check("occupancy", cyc, exp_cyc);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge wb_clk_i) #1;
      is_load = 1'b0; is_store = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_val", wb_val, 0);
    check("rst_wb_idx", wb_idx, 0);
    check("rst_wb_mask", wb_mask, 0);
    @(posedge wb_clk_i) #1 rst = 1'b0;

    // Word load with a slow ack
    mem[32'h40] = 32'hDEADBEEF;
    fixed_delay = 3;
    issue(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 6'd5, 2'd3);
    idle(1);
    // Signed and unsigned byte loads at the top lane
    fixed_delay = -1;
    mem[32'h40] = 32'h80112233;
    issue(1'b1, 1'b1, 2'd0, 32'h103, 32'h0, 6'd6, 2'd1);
    issue(1'b1, 1'b0, 2'd0, 32'h103, 32'h0, 6'd7, 2'd2);
    idle(1);
    // Half store to the upper half
    issue(1'b0, 1'b0, 2'd1, 32'h22, 32'hABCD1234, 6'd0, 2'd0);
    idle(1);
    // Misaligned word load
    issue(1'b1, 1'b0, 2'd2, 32'h101, 32'h0, 6'd10, 2'd3);
    idle(2);

    // Reset while a transaction is on the bus, ack arriving afterwards
    resp_en = 1'b0;
    @(posedge wb_clk_i) #1;
    is_load = 1'b1; is_store = 1'b0; loadstore_size = 2'd2;
    loadstore_address = 32'h200; dest_idx = 6'd9;
    @(negedge wb_clk_i);
    check("rstmid_busy_c0", busy, 1);
    @(negedge wb_clk_i);
    check("rstmid_req_c1", mem_req, 1);
    @(posedge wb_clk_i) #1;
    rst = 1'b1; is_load = 1'b0;
    @(posedge wb_clk_i) #1;
    rst = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      if (i == 1) force_ack = 1'b0;
      check("rstmid_req", mem_req, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_wb_valid", wb_valid, 0);
    end
    resp_en = 1'b1;

    // Back-to-back loads with ack held high
    ack_always = 1'b1; fixed_delay = 0;
    issue(1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 6'd11, 2'd3);
    issue(1'b1, 1'b1, 2'd1, 32'h46, 32'h0, 6'd12, 2'd1);
    idle(1);
    ack_always = 1'b0; fixed_delay = -1;

    // Randomized traffic over a small address window
    for (int n = 0; n < 200; n++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 32'($urandom_range(0, 127)), $urandom,
            6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      idle($urandom_range(0, 2));
    end
    idle(3);
    check("retire_queue_empty", exp_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
